// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-ported, byte-enabled word storage between the instruction-fetch
// port (I) and the load/store port (D); D has priority, a starvation counter protects I.
module memory_port_arbiter #(
  parameter int ADRESS_SIZE  = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   IReq,
  input  logic [ADRESS_SIZE-1:0] IAdress,
  output logic                   IReady,
  output logic                   IRespValid,
  output logic [31:0]            IRespData,
  input  logic                   DReq,
  input  logic                   DWrite,
  input  logic [3:0]             DByteEn,
  input  logic [ADRESS_SIZE-1:0] DAdress,
  input  logic [31:0]            DWriteData,
  output logic                   DReady,
  output logic                   DRespValid,
  output logic [31:0]            DRespData,
  output logic                   MemEn,
  output logic                   WriteEnable,
  output logic [3:0]             ByteEn,
  output logic [ADRESS_SIZE-1:0] MemoryAdress,
  output logic [31:0]            InputData,
  input  logic [31:0]            MemData
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WR_SETUP, WR_COMMIT} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          starve_cnt;
  logic [ADRESS_SIZE-1:0] wr_addr;
  logic [31:0]            wr_data;
  logic [3:0]             wr_be;
  logic                   is_idle, d_first, grant_i, grant_d;

  // Ready is combinational, so it is also gated by reset_n to keep every output low in reset.
  always_comb begin
    is_idle = (state == IDLE) && reset_n;
    d_first = DReq && (starve_cnt < LIMIT);
    grant_d = is_idle && (d_first || (DReq && !IReq));
    grant_i = is_idle && IReq && !d_first;
  end

  // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    IReady       = grant_i;
    DReady       = grant_d;
    MemEn        = 1'b0;
    WriteEnable  = 1'b0;
    ByteEn       = 4'b0000;
    MemoryAdress = '0;
    InputData    = 32'h0;
    unique case (state)
      IDLE: begin
        if (grant_d && DWrite) begin
          state_nxt = WR_SETUP;
        end else if (grant_i) begin
          MemEn        = 1'b1;
          MemoryAdress = IAdress;
        end else if (grant_d) begin
          MemEn        = 1'b1;
          MemoryAdress = DAdress;
        end
      end
      WR_SETUP, WR_COMMIT: begin
        MemEn        = 1'b1;
        WriteEnable  = (state == WR_COMMIT);
        ByteEn       = wr_be;
        MemoryAdress = wr_addr;
        InputData    = wr_data;
        state_nxt    = (state == WR_SETUP) ? WR_COMMIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wr_addr    <= '0;
      wr_data    <= 32'h0;
      wr_be      <= 4'b0000;
      IRespValid <= 1'b0;
      IRespData  <= 32'h0;
      DRespValid <= 1'b0;
      DRespData  <= 32'h0;
    end else begin
      state <= state_nxt;

      // Counts every cycle I waits, including cycles the storage is busy with a write.
      if (grant_i || !IReq)       starve_cnt <= '0;
      else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;

      if (grant_d && DWrite) begin
        wr_addr <= DAdress;
        wr_data <= DWriteData;
        wr_be   <= DByteEn;
      end

      IRespValid <= grant_i;
      if (grant_i) IRespData <= MemData;

      DRespValid <= (grant_d && !DWrite) || (state == WR_COMMIT);
      if (grant_d && !DWrite)      DRespData <= MemData;
      else if (state == WR_COMMIT) DRespData <= 32'h0;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomised and directed bench for memory_port_arbiter: a requester driver, a storage model,
// and a negedge monitor that checks grants, storage bus and responses against a reference model.
module tb_memory_port_arbiter;
  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          IReq, IReady, IRespValid;
  logic [AW-1:0] IAdress;
  logic [31:0]   IRespData;
  logic          DReq, DWrite, DReady, DRespValid;
  logic [3:0]    DByteEn;
  logic [AW-1:0] DAdress;
  logic [31:0]   DWriteData, DRespData;
  logic          MemEn, WriteEnable;
  logic [3:0]    ByteEn;
  logic [AW-1:0] MemoryAdress;
  logic [31:0]   InputData, MemData;

  always #5 clk = ~clk;

  memory_port_arbiter #(.ADRESS_SIZE(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .IReq(IReq), .IAdress(IAdress), .IReady(IReady),
    .IRespValid(IRespValid), .IRespData(IRespData),
    .DReq(DReq), .DWrite(DWrite), .DByteEn(DByteEn), .DAdress(DAdress),
    .DWriteData(DWriteData), .DReady(DReady),
    .DRespValid(DRespValid), .DRespData(DRespData),
    .MemEn(MemEn), .WriteEnable(WriteEnable), .ByteEn(ByteEn),
    .MemoryAdress(MemoryAdress), .InputData(InputData), .MemData(MemData)
  );

  typedef struct {logic [31:0] data; int due;} resp_t;
  typedef struct {logic w; logic [3:0] be; logic [31:0] addr; logic [31:0] data;} dreq_t;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] i_stim [$];
  dreq_t       d_stim [$];
  resp_t       iq [$], dq [$];
  bit          i_acc, d_acc;
  int          errors = 0, checks = 0, ncyc = 0;

  // Reference-model state: cycles I has waited, write phase (0 idle, 1 setup, 2 commit).
  int          i_wait = 0, wr_phase = 0;
  bit          wr_apply = 1'b0;
  dreq_t       wr_cur;

  assign MemData = mem[MemoryAdress[7:2]];

  always @(posedge clk)
    if (MemEn && WriteEnable)
      for (int k = 0; k < 4; k++)
        if (ByteEn[k]) mem[MemoryAdress[7:2]][8*k +: 8] <= InputData[8*k +: 8];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, ncyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  // Requester driver: presents the head of each stimulus queue and holds it until accepted.
  initial begin
    forever begin
      if (i_acc) begin i_stim.delete(0); i_acc = 1'b0; end
      if (d_acc) begin d_stim.delete(0); d_acc = 1'b0; end
      if (i_stim.size() > 0) begin
        IReq = 1'b1; IAdress = i_stim[0];
      end else begin
        IReq = 1'b0; IAdress = $urandom();
      end
      if (d_stim.size() > 0) begin
        DReq = 1'b1; DWrite = d_stim[0].w; DByteEn = d_stim[0].be;
        DAdress = d_stim[0].addr; DWriteData = d_stim[0].data;
      end else begin
        DReq = 1'b0; DWrite = 1'($urandom()); DByteEn = 4'($urandom());
        DAdress = $urandom(); DWriteData = $urandom();
      end
      @(posedge clk); #1;
    end
  end

  // Monitor and reference model, evaluated mid-cycle.
  logic        busy, d_ok, exp_i, exp_d, exp_v;
  logic [95:0] exp_bus;
  resp_t       r;
  always @(negedge clk) begin
    ncyc++;
    if (reset_n) begin
      if (wr_apply) begin
        ref_mem[wr_cur.addr[7:2]] = merge(ref_mem[wr_cur.addr[7:2]], wr_cur.data, wr_cur.be);
        wr_apply = 1'b0;
      end
      busy  = (wr_phase != 0);
      d_ok  = DReq && (i_wait < LIMIT);
      exp_d = !busy && (d_ok || (DReq && !IReq));
      exp_i = !busy && IReq && !d_ok;
      check("i_ready", 96'(IReady), 96'(exp_i));
      check("d_ready", 96'(DReady), 96'(exp_d));

      if (wr_phase == 1)            exp_bus = {26'b0, 2'b10, wr_cur.be, wr_cur.addr, wr_cur.data};
      else if (wr_phase == 2)       exp_bus = {26'b0, 2'b11, wr_cur.be, wr_cur.addr, wr_cur.data};
      else if (exp_i)               exp_bus = {26'b0, 2'b10, 4'b0, IAdress, 32'h0};
      else if (exp_d && !DWrite)    exp_bus = {26'b0, 2'b10, 4'b0, DAdress, 32'h0};
      else                          exp_bus = 96'h0;
      check("mem_bus", {26'b0, MemEn, WriteEnable, ByteEn, MemoryAdress, InputData}, exp_bus);

      exp_v = (iq.size() > 0) && (iq[0].due == ncyc);
      check("i_resp_valid", 96'(IRespValid), 96'(exp_v));
      if (exp_v) begin r = iq.pop_front(); check("i_resp_data", 96'(IRespData), 96'(r.data)); end
      exp_v = (dq.size() > 0) && (dq[0].due == ncyc);
      check("d_resp_valid", 96'(DRespValid), 96'(exp_v));
      if (exp_v) begin r = dq.pop_front(); check("d_resp_data", 96'(DRespData), 96'(r.data)); end

      if (wr_phase == 2) begin wr_apply = 1'b1; wr_phase = 0; end
      else if (wr_phase == 1) wr_phase = 2;

      if (exp_i) begin
        iq.push_back('{ref_mem[IAdress[7:2]], ncyc + 1});
        i_wait = 0;
      end else if (IReq) begin
        i_wait = (i_wait < LIMIT) ? i_wait + 1 : LIMIT;
      end else begin
        i_wait = 0;
      end

      if (exp_d) begin
        if (DWrite) begin
          wr_cur   = '{1'b1, DByteEn, DAdress, DWriteData};
          wr_phase = 1;
          dq.push_back('{32'h0, ncyc + 3});
        end else begin
          dq.push_back('{ref_mem[DAdress[7:2]], ncyc + 1});
        end
      end
      i_acc = IReq && IReady;
      d_acc = DReq && DReady;
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk); #1;
      done = (i_stim.size() == 0) && (d_stim.size() == 0) && (iq.size() == 0) &&
             (dq.size() == 0) && (wr_phase == 0);
    end
    check("drain_within_budget", 96'(done), 96'(1));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_resp"}, {30'b0, IReady, IRespValid, IRespData, DReady, DRespValid, DRespData}, 96'h0);
    check({name, "_bus"}, {26'b0, MemEn, WriteEnable, ByteEn, MemoryAdress, InputData}, 96'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom(); ref_mem[i] = mem[i]; end
    mem[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;

    // Reset held while an I request is already pending: every output must stay low.
    i_stim.push_back(32'h0000_0040);
    #8 check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    wait_idle();

    // Partial store, then load back the merged word.
    d_stim.push_back('{1'b1, 4'b0011, 32'h0000_0080, 32'h1234_5678});
    wait_idle();
    d_stim.push_back('{1'b0, 4'b0000, 32'h0000_0080, 32'h0});
    wait_idle();

    // Simultaneous loads: D first, then I.
    i_stim.push_back(rand_addr());
    d_stim.push_back('{1'b0, 4'b0000, rand_addr(), 32'h0});
    wait_idle();

    // Starvation: D streams loads while I waits.
    i_stim.push_back(rand_addr());
    for (int n = 0; n < 8; n++) d_stim.push_back('{1'b0, 4'b0000, rand_addr(), 32'h0});
    wait_idle();

    // I request arriving while a store occupies the storage.
    d_stim.push_back('{1'b1, 4'($urandom()), rand_addr(), $urandom()});
    for (int n = 0; n < 20 && !d_acc; n++) begin @(negedge clk); #1; end
    i_stim.push_back(rand_addr());
    wait_idle();

    // Random mixed traffic.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      if (i_stim.size() == 0 && $urandom_range(2) == 0) i_stim.push_back(rand_addr());
      if (d_stim.size() == 0 && $urandom_range(1) == 0)
        d_stim.push_back('{($urandom_range(9) < 4), 4'($urandom()), rand_addr(), $urandom()});
    end
    wait_idle();

    // Reset during the commit cycle aborts the store with no response.
    d_stim.push_back('{1'b1, 4'b1111, 32'h0000_00C0, 32'hA5A5_5A5A});
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = WriteEnable; end
      check("reach_commit", 96'(seen), 96'(1));
    end
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset_mid_write");
    iq.delete(); dq.delete(); wr_phase = 0; wr_apply = 1'b0; i_wait = 0;
    i_acc = 1'b0; d_acc = 1'b0;
    d_stim.push_back('{1'b0, 4'b0000, 32'h0000_00C0, 32'h0});
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk); #1 check("d_accept_after_reset", 96'(d_acc), 96'(1));
    wait_idle();

    check("queues_empty", 96'(iq.size() + dq.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
